obuf: RTL and testbench

OBUF -- requirements
Module: obuf

---
 rtl/obuf_pkg.sv | 21 ++
 rtl/obuf_if.sv | 26 ++
 rtl/obuf_fifo.sv | 73 +++++++
 rtl/obuf.sv | 81 ++++++++
 tb/tb_obuf.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/obuf_pkg.sv
// Shared switch definitions for the output buffer: packet word layout,
// destination field range, default FIFO depth and a routing helper.
package obuf_pkg;

  localparam int PKTW       = 16;   // payload+destination width; valid bit sits above it
  localparam int PORT       = 3;    // highest switch output port index
  localparam int VLD_BIT    = PKTW; // packet valid flag position
  localparam int DST_LO     = 0;    // one-hot destination field, low bit
  localparam int DST_HI     = PORT; // one-hot destination field, high bit
  localparam int OBUF_DEPTH = 4;    // default FIFO entries

  typedef logic [PKTW:0] pkt_t;

  // True only when the destination field selects exactly this port and no other.
  function automatic logic dest_ok(input logic [PORT:0] dst, input int portid);
    logic [PORT:0] want_s;
    want_s = (PORT+1)'(1) << portid;
    return dst == want_s;
  endfunction

endpackage

// File: rtl/obuf_if.sv
// Link-side bundle of the output buffer: packet in, head word out with
// valid/ready handshake, status flags and statistics counters.
interface obuf_if;
  import obuf_pkg::*;

  pkt_t        in;
  pkt_t        out;
  logic        out_valid;
  logic        out_ready;
  logic        full;
  logic        empty;
  logic [15:0] pkt_cnt;
  logic [7:0]  drop_cnt;
  logic [7:0]  err_cnt;

  modport slave (
    input  in, out_ready,
    output out, out_valid, full, empty, pkt_cnt, drop_cnt, err_cnt
  );

  modport master (
    output in, out_ready,
    input  out, out_valid, full, empty, pkt_cnt, drop_cnt, err_cnt
  );

endinterface

// File: rtl/obuf_fifo.sv
// Packet storage for one output buffer: circular array with wrapping
// read/write pointers and an occupancy counter one bit wider than them.
module obuf_fifo
  import obuf_pkg::*;
#(
  parameter int DEPTH = OBUF_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  pkt_t wdata,
  output pkt_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  pkt_t          mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full  = (count_r == (AW+1)'(DEPTH));
  assign empty = (count_r == (AW+1)'(0));

  // Guard the strobes so a stray request can never corrupt occupancy.
  always_comb begin
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_ok_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Data array write; contents are left alone by reset since empty masks them.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // Head word is forced to zero whenever nothing is queued.
  always_comb begin
    if (empty) begin
      rdata = '0;
    end else begin
      rdata = mem_r[rptr_r];
    end
  end

endmodule

// File: rtl/obuf.sv
// Output buffer for one switch port: checks routing of each incoming word,
// queues correctly routed packets, drops on overflow and keeps statistics.
module obuf
  import obuf_pkg::*;
#(
  parameter int PORTID = 0,
  parameter int DEPTH  = OBUF_DEPTH
) (
  input  logic   clk,
  input  logic   rst,
  obuf_if.slave  bus
);

  logic        fifo_full_s;
  logic        fifo_empty_s;
  pkt_t        head_s;
  logic        pkt_vld_s;
  logic        route_ok_s;
  logic        pop_s;
  logic        push_s;
  logic        drop_s;
  logic        misroute_s;
  logic [15:0] pkt_cnt_r;
  logic [7:0]  drop_cnt_r;
  logic [7:0]  err_cnt_r;

  obuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (bus.in),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Classify the incoming word and decide push, drop or misroute this cycle.
  always_comb begin
    pkt_vld_s  = bus.in[VLD_BIT];
    route_ok_s = dest_ok(bus.in[DST_HI:DST_LO], PORTID);
    pop_s      = !fifo_empty_s && bus.out_ready;
    if (pkt_vld_s) begin
      misroute_s = !route_ok_s;
      push_s     = route_ok_s && (!fifo_full_s || pop_s);
      drop_s     = route_ok_s && fifo_full_s && !pop_s;
    end else begin
      misroute_s = 1'b0;
      push_s     = 1'b0;
      drop_s     = 1'b0;
    end
  end

  // Saturating statistics counters; reset wins over any event in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_r  <= 16'd0;
      drop_cnt_r <= 8'd0;
      err_cnt_r  <= 8'd0;
    end else begin
      if (pop_s && (pkt_cnt_r != 16'hFFFF)) begin
        pkt_cnt_r <= pkt_cnt_r + 16'd1;
      end
      if (drop_s && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
      if (misroute_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

  assign bus.out       = head_s;
  assign bus.out_valid = !fifo_empty_s;
  assign bus.full      = fifo_full_s;
  assign bus.empty     = fifo_empty_s;
  assign bus.pkt_cnt   = pkt_cnt_r;
  assign bus.drop_cnt  = drop_cnt_r;
  assign bus.err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_obuf.sv
// Randomised, scoreboard-checked bench for the output buffer at PORTID 0.
module tb_obuf;
  import obuf_pkg::*;

  localparam int TB_DEPTH = 4;

  logic clk;
  logic rst;

  obuf_if ifc ();

  obuf #(.PORTID(0), .DEPTH(TB_DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  pkt_t mq[$];      // reference FIFO contents
  pkt_t exp_q[$];   // scoreboard: words the link must receive, in order
  int   m_pkt  = 0;
  int   m_drop = 0;
  int   m_err  = 0;
  bit   model_ok = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // One clock cycle: drive inputs, check pre-edge outputs, advance the model.
  task automatic cycle(input logic r, input logic v, input logic [3:0] d, input logic rdy);
    pkt_t w;
    bit   popm;
    w = {v, 12'($urandom), d};
    rst = r;
    ifc.in = w;
    ifc.out_ready = rdy;
    @(negedge clk);
    if (model_ok) begin
      chk("out_valid", 32'(ifc.out_valid), 32'(mq.size() != 0));
      chk("empty",     32'(ifc.empty),     32'(mq.size() == 0));
      chk("full",      32'(ifc.full),      32'(mq.size() == TB_DEPTH));
      chk("head",      32'(ifc.out),       (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      chk("pkt_cnt",   32'(ifc.pkt_cnt),   32'(m_pkt));
      chk("drop_cnt",  32'(ifc.drop_cnt),  32'(m_drop));
      chk("err_cnt",   32'(ifc.err_cnt),   32'(m_err));
    end
    #1;
    if (r) begin
      mq.delete();
      exp_q.delete();
      m_pkt = 0; m_drop = 0; m_err = 0;
      model_ok = 1'b1;
    end else begin
      popm = rdy && (mq.size() != 0);
      if (popm) begin
        void'(mq.pop_front());
        if (m_pkt < 65535) m_pkt++;
      end
      if (v) begin
        if (!(($countones(d) == 1) && d[0])) begin
          if (m_err < 255) m_err++;
        end else if (mq.size() < TB_DEPTH) begin
          mq.push_back(w);
          exp_q.push_back(w);
        end else begin
          if (m_drop < 255) m_drop++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every accepted head word must match the oldest expected one.
  initial begin
    pkt_t e;
    forever begin
      @(negedge clk);
      if (!rst && (ifc.out_valid === 1'b1) && (ifc.out_ready === 1'b1)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected actual=%0h required=none at %0t", ifc.out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_out", 32'(ifc.out), 32'(e));
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pct;
    rst = 1'b1;
    ifc.in = '0;
    ifc.out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state.
    do_reset();
    chk("rst_empty", 32'(ifc.empty), 32'd1);
    chk("rst_full",  32'(ifc.full),  32'd0);
    chk("rst_out",   32'(ifc.out),   32'd0);

    // Three packets straight through with the link ready.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'b0001, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 4'b0001, 1'b1);
    chk("t33_pkt",  32'(ifc.pkt_cnt),  32'd3);
    chk("t33_drop", 32'(ifc.drop_cnt), 32'd0);

    // Six packets into a stalled link: four queued, two dropped, then drain.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'b0001, 1'b0);
    chk("t34_full", 32'(ifc.full), 32'd1);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 4'b0001, 1'b0);
    chk("t34_drop", 32'(ifc.drop_cnt), 32'd2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 4'b0001, 1'b1);
    chk("t34_empty", 32'(ifc.empty),   32'd1);
    chk("t34_pkt",   32'(ifc.pkt_cnt), 32'd4);

    // Full FIFO with a same-cycle pop accepts the incoming packet.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'b0001, 1'b0);
    cycle(1'b0, 1'b1, 4'b0001, 1'b1);
    chk("t35_full", 32'(ifc.full),     32'd1);
    chk("t35_drop", 32'(ifc.drop_cnt), 32'd0);
    chk("t35_pkt",  32'(ifc.pkt_cnt),  32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 4'b0001, 1'b1);

    // Misrouted packets and an invalid word.
    do_reset();
    cycle(1'b0, 1'b1, 4'b0010, 1'b1);
    cycle(1'b0, 1'b1, 4'b0011, 1'b1);
    cycle(1'b0, 1'b0, 4'b0001, 1'b1);
    chk("t36_err",   32'(ifc.err_cnt), 32'd2);
    chk("t36_empty", 32'(ifc.empty),   32'd1);

    // Reset mid-operation with queued packets and a valid incoming word.
    do_reset();
    cycle(1'b0, 1'b1, 4'b1000, 1'b0);
    cycle(1'b0, 1'b1, 4'b0001, 1'b0);
    cycle(1'b0, 1'b1, 4'b0001, 1'b0);
    cycle(1'b1, 1'b1, 4'b0001, 1'b0);
    rst = 1'b0;
    chk("t37_empty", 32'(ifc.empty),     32'd1);
    chk("t37_valid", 32'(ifc.out_valid), 32'd0);
    chk("t37_out",   32'(ifc.out),       32'd0);
    chk("t37_pkt",   32'(ifc.pkt_cnt),   32'd0);
    chk("t37_drop",  32'(ifc.drop_cnt),  32'd0);
    chk("t37_err",   32'(ifc.err_cnt),   32'd0);
    cycle(1'b0, 1'b0, 4'b0001, 1'b0);

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'b0001, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 4'b0001, 1'b0);
    chk("t38_drop", 32'(ifc.drop_cnt), 32'd255);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'b0001, 1'b1);

    // Randomised traffic, first with a mostly-ready link then a mostly-stalled one.
    do_reset();
    for (int ph = 0; ph < 2; ph++) begin
      pct = (ph == 0) ? 70 : 30;
      for (int i = 0; i < 1500; i++) begin
        cycle(1'b0,
              1'($urandom_range(0, 3) != 0),
              ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0001,
              1'($urandom_range(0, 99) < pct));
      end
    end
    for (int i = 0; i < TB_DEPTH + 2; i++) cycle(1'b0, 1'b0, 4'b0001, 1'b1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("end_empty",  32'(ifc.empty),    32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
